mem_access_unit: RTL and testbench

//  Memory stage directly downstream of the RV32I ALU stage. Consumes ls_op, the ALU-computed address and result, and rs2 store data.

---
 rtl/mem_access_unit_pkg.sv | 53 +++++
 rtl/mem_access_unit_if.sv | 45 ++++
 rtl/mem_access_unit_load_align.sv | 34 +++
 rtl/mem_access_unit.sv | 185 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg
//   Shared definitions for the RV32I memory-access stage: load/store op
//   encodings, FSM state codes, byte-strobe constants and small op
//   classification helpers used by the top and the load aligner.
package mem_access_unit_pkg;

  typedef enum logic [4:0] {
    LS_NONE  = 5'h00,
    LS_LB    = 5'h01,
    LS_LH    = 5'h02,
    LS_LW    = 5'h03,
    LS_LUI   = 5'h04,
    LS_AUIPC = 5'h05,
    LS_SB    = 5'h06,
    LS_SH    = 5'h07,
    LS_SW    = 5'h08,
    LS_LBU   = 5'h09,
    LS_LHU   = 5'h0A
  } ls_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT_R = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  localparam logic [3:0] STRB_NONE    = 4'b0000;
  localparam logic [3:0] STRB_BYTE0   = 4'b0001;
  localparam logic [3:0] STRB_HALF_LO = 4'b0011;
  localparam logic [3:0] STRB_HALF_HI = 4'b1100;
  localparam logic [3:0] STRB_WORD    = 4'b1111;

  function automatic logic is_load(input logic [4:0] op);
    return (op == LS_LB) || (op == LS_LH) || (op == LS_LW) ||
           (op == LS_LBU) || (op == LS_LHU);
  endfunction

  function automatic logic is_store(input logic [4:0] op);
    return (op == LS_SB) || (op == LS_SH) || (op == LS_SW);
  endfunction

  // Byte accesses can never be misaligned; halves need addr[0]==0,
  // words need addr[1:0]==0.
  function automatic logic is_misaligned(input logic [4:0] op, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    if ((op == LS_LH) || (op == LS_LHU) || (op == LS_SH)) mis = off[0];
    if ((op == LS_LW) || (op == LS_SW))                   mis = (off != 2'b00);
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if
//   Bundles the three handshakes of the memory stage:
//     upstream    in_valid/in_ready + ls_op, address, alu_rd, store_data, rd_idx
//     data bus    mem_req/mem_gnt/mem_rvalid + addr, we, wdata, wstrb, rdata
//     writeback   out_valid/out_ready + out_we, out_rd_idx, out_rd_data, out_err
//   master: the memory stage itself. slave: its environment (ALU, memory, WB).
interface mem_access_unit_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  ls_op;
  logic [31:0] address;
  logic [31:0] alu_rd;
  logic [31:0] store_data;
  logic [4:0]  rd_idx;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  logic        out_valid;
  logic        out_ready;
  logic        out_we;
  logic [4:0]  out_rd_idx;
  logic [31:0] out_rd_data;
  logic        out_err;

  modport master (
    input  in_valid, ls_op, address, alu_rd, store_data, rd_idx,
           mem_gnt, mem_rvalid, mem_rdata, out_ready,
    output in_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
           out_valid, out_we, out_rd_idx, out_rd_data, out_err
  );

  modport slave (
    output in_valid, ls_op, address, alu_rd, store_data, rd_idx,
           mem_gnt, mem_rvalid, mem_rdata, out_ready,
    input  in_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
           out_valid, out_we, out_rd_idx, out_rd_data, out_err
  );
endinterface

// File: rtl/mem_access_unit_load_align.sv
// mem_load_align
//   Combinational load-data extraction: selects the addressed byte/half of
//   the returned bus word and sign- or zero-extends it to 32 bits.
//   rdata_i   returned bus word
//   off_i     address[1:0] of the access
//   ls_op_i   load op (lb/lh/lw/lbu/lhu; anything else yields 0)
//   value_o   extended writeback value
module mem_load_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [4:0]  ls_op_i,
  output logic [31:0] value_o
);

  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  always_comb begin
    byte_s  = rdata_i[{off_i, 3'b000} +: 8];
    half_s  = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    value_o = 32'h0;
    case (ls_op_i)
      LS_LB:   value_o = 32'(byte_s);
      LS_LH:   value_o = 32'(half_s);
      LS_LBU:  value_o = {24'h0, byte_s};
      LS_LHU:  value_o = {16'h0, half_s};
      LS_LW:   value_o = rdata_i;
      default: value_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   RV32I memory stage behind the ALU. Accepts one op at a time, runs loads
//   and stores over a req/gnt/rvalid bus with byte-lane placement, detects
//   misalignment and bus timeouts, passes non-memory results through, and
//   hands each result to writeback over valid/ready.
//   clk, reset   rising-edge clock, synchronous active-high reset
//   bus          mem_access_unit_if.master (upstream, data bus, writeback)
//   TIMEOUT_CYCLES (1..255): cycles allowed in REQ+WAIT_R before abort.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic              clk,
  input logic              reset,
  mem_access_unit_if.master bus
);

  // Counter value seen during the last permitted REQ/WAIT_R cycle.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;

  logic [4:0]  op_q, rd_q;
  logic [31:0] addr_q, sdata_q;

  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_we_q, resp_we_d;
  logic        resp_err_q, resp_err_d;
  logic        resp_load;

  logic        accept;
  logic        timeout_hit;
  logic        in_mis;
  logic [31:0] load_val;
  logic [31:0] wdata;
  logic [3:0]  wstrb;

  assign accept      = bus.in_valid && (state_q == ST_IDLE);
  assign timeout_hit = (cnt_q == TO_LAST);
  assign in_mis      = is_misaligned(bus.ls_op, bus.address[1:0]);

  mem_load_align u_load_align (
    .rdata_i (bus.mem_rdata),
    .off_i   (addr_q[1:0]),
    .ls_op_i (op_q),
    .value_o (load_val)
  );

  // State register and timeout counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Op capture at accept, response capture on entry to RESP
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q    <= bus.ls_op;
      addr_q  <= bus.address;
      sdata_q <= bus.store_data;
      rd_q    <= bus.rd_idx;
    end
    if (resp_load) begin
      resp_data_q <= resp_data_d;
      resp_we_q   <= resp_we_d;
      resp_err_q  <= resp_err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    resp_load   = 1'b0;
    resp_data_d = 32'h0;
    resp_we_d   = 1'b0;
    resp_err_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = 8'h0;
        if (accept) begin
          if ((is_load(bus.ls_op) || is_store(bus.ls_op)) && !in_mis) begin
            state_d = ST_REQ;
          end else begin
            state_d   = ST_RESP;
            resp_load = 1'b1;
            if (in_mis) begin
              resp_err_d = 1'b1;
            end else begin
              resp_data_d = bus.alu_rd;
              resp_we_d   = (bus.rd_idx != 5'd0);
            end
          end
        end
      end
      ST_REQ: begin
        cnt_d = cnt_q + 8'd1;
        // A grant in the final allowed cycle still completes a store, but a
        // load would need at least one more cycle for its data, so it aborts.
        if (bus.mem_gnt && is_store(op_q)) begin
          state_d   = ST_RESP;
          resp_load = 1'b1;
          cnt_d     = 8'h0;
        end else if (timeout_hit) begin
          state_d    = ST_RESP;
          resp_load  = 1'b1;
          resp_err_d = 1'b1;
          cnt_d      = 8'h0;
        end else if (bus.mem_gnt) begin
          state_d = ST_WAIT_R;
        end
      end
      ST_WAIT_R: begin
        cnt_d = cnt_q + 8'd1;
        if (bus.mem_rvalid) begin
          state_d     = ST_RESP;
          resp_load   = 1'b1;
          resp_data_d = load_val;
          resp_we_d   = (rd_q != 5'd0);
          cnt_d       = 8'h0;
        end else if (timeout_hit) begin
          state_d    = ST_RESP;
          resp_load  = 1'b1;
          resp_err_d = 1'b1;
          cnt_d      = 8'h0;
        end
      end
      ST_RESP: begin
        cnt_d = 8'h0;
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'h0;
      end
    endcase
  end

  // Store lane placement; loads and non-memory ops drive no strobes.
  always_comb begin
    wdata = 32'h0;
    wstrb = STRB_NONE;
    case (op_q)
      LS_SB: begin
        wdata = {4{sdata_q[7:0]}};
        wstrb = STRB_BYTE0 << addr_q[1:0];
      end
      LS_SH: begin
        wdata = {2{sdata_q[15:0]}};
        wstrb = addr_q[1] ? STRB_HALF_HI : STRB_HALF_LO;
      end
      LS_SW: begin
        wdata = sdata_q;
        wstrb = STRB_WORD;
      end
      default: begin
        wdata = 32'h0;
        wstrb = STRB_NONE;
      end
    endcase
  end

  // Outputs are gated by state so everything reads 0 outside its phase.
  always_comb begin
    bus.in_ready    = (state_q == ST_IDLE);
    bus.mem_req     = (state_q == ST_REQ);
    bus.mem_we      = (state_q == ST_REQ) && is_store(op_q);
    bus.mem_addr    = (state_q == ST_REQ) ? {addr_q[31:2], 2'b00} : 32'h0;
    bus.mem_wdata   = (state_q == ST_REQ) ? wdata : 32'h0;
    bus.mem_wstrb   = (state_q == ST_REQ) ? wstrb : STRB_NONE;
    bus.out_valid   = (state_q == ST_RESP);
    bus.out_we      = (state_q == ST_RESP) && resp_we_q;
    bus.out_rd_idx  = (state_q == ST_RESP) ? rd_q : 5'd0;
    bus.out_rd_data = (state_q == ST_RESP) ? resp_data_q : 32'h0;
    bus.out_err     = (state_q == ST_RESP) && resp_err_q;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int T = 255;
  localparam int NEVER = 100000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_access_unit_if bus();

  mem_access_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    bit          req;
    bit          we_bus;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    bit          st;
    bit          err;
    bit          rwe;
    logic [31:0] rdata;
    bit          chk_data;
    int          lat;
  } exp_t;

  // Reference: result of one op from its encoding, address, operands, the
  // word memory returns and the bus delays (gd = idle req cycles before gnt,
  // rvd = cycles after gnt before rvalid).
  function automatic exp_t model(input int op, input logic [31:0] a, input logic [31:0] alu,
                                 input logic [31:0] sd, input logic [4:0] rd,
                                 input logic [31:0] mrd, input int gd, input int rvd);
    exp_t   e;
    int     off, size, need;
    bit     ld, st;
    longint v, span;
    off  = int'(a % 4);
    ld   = (op == 1) || (op == 2) || (op == 3) || (op == 9) || (op == 10);
    st   = (op == 6) || (op == 7) || (op == 8);
    size = (op == 1 || op == 9 || op == 6) ? 1 : (op == 2 || op == 10 || op == 7) ? 2 : 4;
    e.req = 0; e.we_bus = 0; e.addr = a - (a % 4); e.wdata = 0; e.wstrb = 0; e.st = st;
    e.err = 0; e.rwe = 0; e.rdata = 0; e.chk_data = 0; e.lat = 1;
    if (!(ld || st)) begin
      e.rwe = (rd != 0); e.rdata = alu; e.chk_data = 1;
    end else if ((off % size) != 0) begin
      e.err = 1;
    end else begin
      e.req = 1;
      e.we_bus = st;
      if (st) begin
        e.wstrb = 4'(((1 << size) - 1) << off);
        if (size == 1)      e.wdata = {24'h0, sd[7:0]} * 32'h01010101;
        else if (size == 2) e.wdata = {16'h0, sd[15:0]} * 32'h00010001;
        else                e.wdata = sd;
      end
      need = st ? gd + 1 : gd + rvd + 2;
      if (need > T) begin
        e.err = 1; e.lat = 1 + T;
      end else begin
        e.lat = 1 + need;
        if (ld) begin
          span = longint'(1) << (8 * size);
          v = longint'(mrd >> (8 * off)) % span;
          if ((op == 1 || op == 2) && v >= span / 2) v = v - span;
          e.rdata = v[31:0];
          e.rwe = (rd != 0);
          e.chk_data = 1;
        end
      end
    end
    return e;
  endfunction

  task automatic recover();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] alu,
                        input logic [31:0] sd, input logic [4:0] rd, input logic [31:0] mrd,
                        input int gd, input int rvd, input int rdy);
    exp_t e;
    int   k, gcnt, rcnt;
    bit   done, req_seen, gdone;
    e = model(op, a, alu, sd, rd, mrd, gd, rvd);
    @(negedge clk);
    check("idle_in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1; bus.ls_op = 5'(op); bus.address = a; bus.alu_rd = alu;
    bus.store_data = sd; bus.rd_idx = rd; bus.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    // Scramble the inputs: the op must have been registered at accept.
    bus.in_valid = 1'b0; bus.ls_op = 5'($urandom_range(0, 10)); bus.address = $urandom;
    bus.alu_rd = $urandom; bus.store_data = $urandom; bus.rd_idx = 5'($urandom);
    k = 1; gcnt = 0; rcnt = 0; done = 0; req_seen = 0; gdone = 0;
    while (!done && k < T + 20) begin
      bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
      if (bus.out_valid) begin
        done = 1;
      end else begin
        if (bus.mem_req) begin
          if (!req_seen) begin
            check("mem_addr", bus.mem_addr, e.addr);
            check("mem_we", 32'(bus.mem_we), 32'(e.we_bus));
            check("mem_wstrb", 32'(bus.mem_wstrb), 32'(e.wstrb));
            if (e.st) check("mem_wdata", bus.mem_wdata, e.wdata);
          end
          req_seen = 1;
          if (gcnt == gd) begin
            bus.mem_gnt = 1'b1;
            gdone = 1;
            // rvalid alongside the grant must not be taken as load data
            bus.mem_rvalid = 1'($urandom_range(0, 1));
            bus.mem_rdata = $urandom;
          end
          gcnt++;
        end else if (gdone && !e.st) begin
          if (rcnt == rvd) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata = mrd;
          end else begin
            bus.mem_gnt = 1'($urandom_range(0, 1));
            bus.mem_rdata = $urandom;
          end
          rcnt++;
        end
        @(posedge clk);
        @(negedge clk);
        k++;
      end
    end
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
    if (!done) begin
      check("resp_timeout", 32'd0, 32'd1);
      recover();
    end else begin
      check("latency", 32'(k), 32'(e.lat));
      check("req_seen", 32'(req_seen), 32'(e.req));
      check("out_err", 32'(bus.out_err), 32'(e.err));
      check("out_we", 32'(bus.out_we), 32'(e.rwe));
      check("out_rd_idx", 32'(bus.out_rd_idx), 32'(rd));
      if (e.chk_data) check("out_rd_data", bus.out_rd_data, e.rdata);
      for (int i = 0; i < rdy; i++) begin
        @(posedge clk);
        @(negedge clk);
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        check("hold_err", 32'(bus.out_err), 32'(e.err));
        check("hold_we", 32'(bus.out_we), 32'(e.rwe));
        check("hold_idx", 32'(bus.out_rd_idx), 32'(rd));
        if (e.chk_data) check("hold_data", bus.out_rd_data, e.rdata);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("drain_valid", 32'(bus.out_valid), 32'd0);
      check("drain_in_ready", 32'(bus.in_ready), 32'd1);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.ls_op = 5'd0; bus.address = 32'h0; bus.alu_rd = 32'h0;
    bus.store_data = 32'h0; bus.rd_idx = 5'd0; bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
    bus.mem_rdata = 32'h0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check("rst_mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_we", 32'(bus.out_we), 32'd0);
    check("rst_out_idx", 32'(bus.out_rd_idx), 32'd0);
    check("rst_out_data", bus.out_rd_data, 32'd0);
    check("rst_out_err", 32'(bus.out_err), 32'd0);
    reset = 1'b0;

    // Directed cases
    run_op(3,  32'h100, 32'h11111111, 32'h0, 5'd5,  32'hDEADBEEF, 0, 0, 0);
    run_op(1,  32'h103, 32'h0, 32'h0, 5'd6,  32'h80123456, 0, 0, 0);
    run_op(9,  32'h103, 32'h0, 32'h0, 5'd7,  32'h80123456, 0, 0, 0);
    run_op(2,  32'h102, 32'h0, 32'h0, 5'd8,  32'h9ABC0000, 1, 2, 0);
    run_op(10, 32'h102, 32'h0, 32'h0, 5'd8,  32'h9ABC0000, 0, 0, 1);
    run_op(7,  32'h202, 32'h0, 32'h1234ABCD, 5'd9, 32'h0, 0, 0, 3);
    run_op(6,  32'h301, 32'h0, 32'h000000A5, 5'd1, 32'h0, 2, 0, 0);
    run_op(8,  32'h101, 32'h0, 32'h55555555, 5'd4, 32'h0, 0, 0, 0);
    run_op(2,  32'h105, 32'h0, 32'h0, 5'd4, 32'h0, 0, 0, 0);
    run_op(4,  32'h0, 32'hCAFE0000, 32'h0, 5'd0, 32'h0, 0, 0, 0);
    run_op(5,  32'h0, 32'h00401000, 32'h0, 5'd31, 32'h0, 0, 0, 0);
    run_op(3,  32'h0, 32'h0, 32'h0, 5'd0, 32'h76543210, 0, 1, 0);

    // Grant never arrives: abort with error, then a stray rvalid is ignored.
    run_op(3, 32'h40, 32'h0, 32'h0, 5'd3, 32'h0, NEVER, 0, 0);
    bus.mem_rvalid = 1'b1; bus.mem_gnt = 1'b1; bus.mem_rdata = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    bus.mem_rvalid = 1'b0; bus.mem_gnt = 1'b0;
    check("post_to_valid", 32'(bus.out_valid), 32'd0);
    check("post_to_in_ready", 32'(bus.in_ready), 32'd1);
    check("post_to_req", 32'(bus.mem_req), 32'd0);

    // Store granted in the last allowed cycle still completes cleanly.
    run_op(8, 32'h80, 32'h0, 32'hA5A5A5A5, 5'd2, 32'h0, T - 1, 0, 0);
    // Load granted in the last allowed cycle cannot finish in time.
    run_op(3, 32'h84, 32'h0, 32'h0, 5'd2, 32'h1, T - 1, 0, 0);

    // Reset while waiting for load data.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.ls_op = 5'd3; bus.address = 32'h10; bus.rd_idx = 5'd3;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("rstmid_req", 32'(bus.mem_req), 32'd1);
    bus.mem_gnt = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    check("rstmid_wait", 32'(bus.mem_req), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rstmid_req_low", 32'(bus.mem_req), 32'd0);
    check("rstmid_valid_low", 32'(bus.out_valid), 32'd0);
    check("rstmid_in_ready", 32'(bus.in_ready), 32'd1);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hFFFFFFFF;
    @(posedge clk);
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    check("rstmid_stray_rvalid", 32'(bus.out_valid), 32'd0);
    check("rstmid_still_idle", 32'(bus.in_ready), 32'd1);

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      run_op($urandom_range(0, 10), $urandom, $urandom, $urandom, 5'($urandom),
             $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
